// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and imem fetch sequencer feeding decode.
// Define IMISALIGN_CHK_EN to redirect fetch to TRAP_PC on a misaligned npc.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] TRAP_PC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic        misalign_err,
    output logic [31:0] bad_npc
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d, instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fetch_err_q, fetch_err_d;
    logic          hs;
    assign hs = (state_q == S_HOLD) && instr_ready;
`ifdef IMISALIGN_CHK_EN
    logic        misalign_q, misalign_d;
    logic [31:0] bad_npc_q, bad_npc_d;
    // flag a misaligned npc on the decode handshake and remember it
    always_comb begin
        misalign_d = hs && (npc[1:0] != 2'b00);
        bad_npc_d  = misalign_d ? npc : bad_npc_q;
    end
    // misalign pulse and captured address
    always_ff @(posedge clk) begin
        if (!rstn) begin
            misalign_q <= 1'b0;
            bad_npc_q  <= '0;
        end else begin
            misalign_q <= misalign_d;
            bad_npc_q  <= bad_npc_d;
        end
    end
    assign misalign_err = misalign_q;
    assign bad_npc      = bad_npc_q;
`else
    logic unused_cfg;
    assign unused_cfg   = ^{npc[1:0], TRAP_PC};
    assign misalign_err = 1'b0;
    assign bad_npc      = '0;
`endif
    // next state: fetch, hold for decode, advance pc on handshake
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fetch_err_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (hs) begin
`ifdef IMISALIGN_CHK_EN
                    pc_d = misalign_d ? TRAP_PC : npc;
`else
                    pc_d = {npc[31:2], 2'b00};
`endif
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_REQ);
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and random fetch/decode traffic against a transaction model.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] TRAP   = 32'h0000_4180;
    localparam int          TMO    = 16;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] npc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic [31:0] pc, imem_addr, instr, bad_npc;
    logic        imem_req, instr_valid, fetch_err, misalign_err;
    int total = 0;
    int bad = 0;
    logic [31:0] m_pc = RST_PC, m_instr = '0, m_bad = '0;
    logic        m_have = 1'b0, m_wanting = 1'b0, m_err = 1'b0, m_mis = 1'b0;
    int          m_waited = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .rstn(rstn), .npc(npc), .pc(pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_err(fetch_err), .misalign_err(misalign_err), .bad_npc(bad_npc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // transaction-level view: an instruction is either owed by imem, held for decode, or neither (startup)
    task automatic model_edge(input logic r, input logic a, input logic [31:0] rd, input logic rdy, input logic [31:0] n);
        if (!r) begin
            m_pc = RST_PC; m_instr = '0; m_have = 0; m_wanting = 0;
            m_waited = 0; m_err = 0; m_mis = 0; m_bad = '0;
        end else begin
            m_mis = 0;
            if (m_have) begin
                if (rdy) begin
                    m_have = 0;
                    m_wanting = 1;
`ifdef IMISALIGN_CHK_EN
                    if (n % 4 != 0) begin
                        m_pc = TRAP; m_bad = n; m_mis = 1;
                    end else m_pc = n;
`else
                    m_pc = n & ~32'd3;
`endif
                end
            end else if (m_wanting) begin
                if (a) begin
                    m_instr = rd; m_have = 1; m_wanting = 0; m_waited = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TMO) begin
                        m_err = 1; m_waited = 0;
                    end
                end
            end else m_wanting = 1;
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_wanting});
        if (m_wanting) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        chk("instr", instr, m_instr);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("bad_npc", bad_npc, m_bad);
    endtask

    task automatic step(input logic r, input logic a, input logic rdy, input logic [31:0] delta, input logic [31:0] rd);
        rstn = r; imem_ack = a; instr_ready = rdy; imem_rdata = rd; npc = m_pc + delta;
        @(posedge clk);
        model_edge(r, a, rd, rdy, npc);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(0, 1, 1, 4, 32'hdead_beef);
        step(0, 1, 1, 4, 32'hdead_beef);
    endtask

    initial begin
        logic [31:0] deltas [8];
        logic [31:0] pc_hold;
        deltas = '{32'd4, 32'd8, 32'd12, -32'd4, 32'h40, 32'd6, 32'd1, 32'd3};
        // reset and startup latency
        do_reset();
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        // zero-wait stream
        step(1, 1, 1, 4, 32'h2408_0005);
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h3000);
        step(1, 1, 1, 4, 32'h2408_0005);
        chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_instr", instr, 32'h2408_0005);
        step(1, 1, 1, 4, 32'h2408_0005);
        chk("zw_pc1", pc, 32'h3004);
        step(1, 1, 1, 4, 32'h2408_0005);
        step(1, 1, 1, 4, 32'h2408_0005);
        chk("zw_pc2", pc, 32'h3008);
        // wait states: ack arrives on the fourth request cycle
        for (int i = 0; i < 3; i++) step(1, 0, 1, 4, 32'h1111_0000 + i);
        chk("ws_addr", imem_addr, 32'h3008);
        step(1, 1, 0, 4, 32'h1234_5678);
        chk("ws_instr", instr, 32'h1234_5678);
        // backpressure with a changing npc
        pc_hold = pc;
        for (int i = 0; i < 5; i++) step(1, 1, 0, deltas[i], $urandom);
        chk("bp_pc", pc, pc_hold);
        chk("bp_instr", instr, 32'h1234_5678);
        step(1, 1, 1, 32'h20, 32'h0);
        chk("bp_release_pc", pc, pc_hold + 32'h20);
        // timeout and recovery
        do_reset();
        step(1, 0, 0, 4, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 4, 0);
        chk("tmo_before", {31'd0, fetch_err}, 32'd0);
        step(1, 0, 0, 4, 0);
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4, 0);
        chk("tmo_req", {31'd0, imem_req}, 32'd1);
        step(1, 1, 0, 4, 32'hcafe_0001);
        chk("tmo_hold", {31'd0, instr_valid}, 32'd1);
        // misaligned npc at the handshake
        do_reset();
        step(1, 1, 0, 4, 0);
        step(1, 1, 0, 4, 32'h0000_0013);
        step(1, 1, 1, 6, 0);
`ifdef IMISALIGN_CHK_EN
        chk("mis_pc", pc, 32'h4180);
        chk("mis_bad", bad_npc, 32'h3006);
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
`else
        chk("mis_pc", pc, 32'h3004);
        chk("mis_pulse", {31'd0, misalign_err}, 32'd0);
`endif
        step(1, 0, 0, 4, 0);
        chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
        // random traffic, occasional mid-flight reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 6, deltas[$urandom_range(0, 7)], $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
